// File: rtl/pilha_hw_if.sv
// pilha_hw_if: push/pop strobes, write word and stack status between the control unit and the stack.
// The master is the control unit; the slave is the stack itself.
interface pilha_hw_if #(
  parameter int LARGURA = 32,
  parameter int PONT_W  = 4
);
  logic               push;
  logic               pop;
  logic [LARGURA-1:0] dado_in;
  logic [LARGURA-1:0] topo;
  logic               vazia;
  logic               cheia;
  logic [PONT_W:0]    ocupacao;
  logic               erro_overflow;
  logic               erro_underflow;

  modport master (
    output push, pop, dado_in,
    input  topo, vazia, cheia, ocupacao, erro_overflow, erro_underflow
  );

  modport slave (
    input  push, pop, dado_in,
    output topo, vazia, cheia, ocupacao, erro_overflow, erro_underflow
  );
endinterface

// File: rtl/pilha_hw.sv
// pilha_hw: LIFO return/data stack with sticky overflow/underflow flags.
// Latency: topo is a zero-cycle combinational read; push/pop take effect on the next posedge.
// Backpressure: none; push while full is dropped (or overwrites the oldest entry with PILHA_CIRCULAR_EN).
module pilha_hw #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 16,
  parameter int PONT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  pilha_hw_if.slave  bus
);

  logic [LARGURA-1:0] r_mem [PROFUNDIDADE];
  logic [PONT_W:0]    r_sp;
  logic               r_ovf;
  logic               r_unf;

  logic               w_vazia;
  logic               w_cheia;
  logic [PONT_W-1:0]  w_base;
  logic [PONT_W-1:0]  w_idx_topo;
  logic [PONT_W-1:0]  w_idx_livre;
  logic [PONT_W-1:0]  w_idx_wr;
  logic               w_we;

`ifdef PILHA_CIRCULAR_EN
  logic [PONT_W-1:0]  r_base;
  assign w_base = r_base;
`else
  assign w_base = '0;
`endif

  assign w_vazia = (r_sp == '0);
  assign w_cheia = (r_sp == (PONT_W+1)'(PROFUNDIDADE));

  // Physical slots are relative to the ring base; the low sp bits wrap to 0 when full.
  assign w_idx_topo  = w_base + r_sp[PONT_W-1:0] - PONT_W'(1);
  assign w_idx_livre = w_base + r_sp[PONT_W-1:0];

`ifdef PILHA_CIRCULAR_EN
  assign w_we = !reset && bus.push;
`else
  assign w_we = !reset && bus.push && (bus.pop || !w_cheia);
`endif

  assign w_idx_wr = (bus.push && bus.pop && !w_vazia) ? w_idx_topo : w_idx_livre;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_idx_wr] <= bus.dado_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
`ifdef PILHA_CIRCULAR_EN
      r_base <= '0;
`endif
    end else if (bus.push && bus.pop) begin
      // Simultaneous push/pop replaces the top; on an empty stack it is a plain push.
      if (w_vazia) begin
        r_sp <= r_sp + (PONT_W+1)'(1);
      end
    end else if (bus.push) begin
      if (!w_cheia) begin
        r_sp <= r_sp + (PONT_W+1)'(1);
      end else begin
        r_ovf <= 1'b1;
`ifdef PILHA_CIRCULAR_EN
        r_base <= r_base + PONT_W'(1);
`endif
      end
    end else if (bus.pop) begin
      if (!w_vazia) begin
        r_sp <= r_sp - (PONT_W+1)'(1);
      end else begin
        r_unf <= 1'b1;
      end
    end
  end

  assign bus.topo           = w_vazia ? '0 : r_mem[w_idx_topo];
  assign bus.vazia          = w_vazia;
  assign bus.cheia          = w_cheia;
  assign bus.ocupacao       = r_sp;
  assign bus.erro_overflow  = r_ovf;
  assign bus.erro_underflow = r_unf;

endmodule

// File: tb/tb_pilha_hw.sv
// Directed bench for pilha_hw; inputs change on negedge, outputs are checked away from posedge.
module tb_pilha_hw;

  localparam int LARGURA      = 32;
  localparam int PROFUNDIDADE = 16;
  localparam int PONT_W       = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pilha_hw_if #(.LARGURA(LARGURA), .PONT_W(PONT_W)) bus ();

  pilha_hw #(
    .LARGURA(LARGURA), .PROFUNDIDADE(PROFUNDIDADE), .PONT_W(PONT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [31:0] d);
    bus.push    = p;
    bus.pop     = q;
    bus.dado_in = d;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.dado_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_vazia", 32'(bus.vazia), 32'd1);
    chk("rst_cheia", 32'(bus.cheia), 32'd0);
    chk("rst_ocup", 32'(bus.ocupacao), 32'd0);
    chk("rst_topo", bus.topo, 32'd0);
    chk("rst_ovf", 32'(bus.erro_overflow), 32'd0);
    chk("rst_unf", 32'(bus.erro_underflow), 32'd0);

    step(1, 0, 32'h10);
    step(1, 0, 32'h20);
    step(1, 0, 32'h30);
    bus.push = 1'b0;
    chk("push3_ocup", 32'(bus.ocupacao), 32'd3);
    chk("push3_topo", bus.topo, 32'h30);
    chk("push3_vazia", 32'(bus.vazia), 32'd0);

    bus.pop = 1'b1;
    #1;
    chk("pop_topo_during", bus.topo, 32'h30);
    @(negedge clk);
    bus.pop = 1'b0;
    chk("pop_topo_after", bus.topo, 32'h20);
    chk("pop_ocup", 32'(bus.ocupacao), 32'd2);

    step(1, 1, 32'hDEADBEEF);
    bus.push = 1'b0;
    bus.pop = 1'b0;
    chk("pp_ocup", 32'(bus.ocupacao), 32'd2);
    chk("pp_topo", bus.topo, 32'hDEADBEEF);
    chk("pp_ovf", 32'(bus.erro_overflow), 32'd0);
    chk("pp_unf", 32'(bus.erro_underflow), 32'd0);

    // Push+pop on an empty stack acts as a plain push without underflow.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step(1, 1, 32'hA5);
    bus.push = 1'b0;
    bus.pop = 1'b0;
    chk("ppe_ocup", 32'(bus.ocupacao), 32'd1);
    chk("ppe_topo", bus.topo, 32'hA5);
    chk("ppe_unf", 32'(bus.erro_underflow), 32'd0);

    // Fill with push held high across 16 cycles.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) step(1, 0, 32'(i));
    bus.push = 1'b0;
    chk("full_cheia", 32'(bus.cheia), 32'd1);
    chk("full_ocup", 32'(bus.ocupacao), 32'd16);
    chk("full_topo", bus.topo, 32'd16);
    chk("full_ovf_clear", 32'(bus.erro_overflow), 32'd0);

    step(1, 0, 32'd17);
    bus.push = 1'b0;
    chk("ovf_cheia", 32'(bus.cheia), 32'd1);
    chk("ovf_flag", 32'(bus.erro_overflow), 32'd1);
    chk("ovf_ocup", 32'(bus.ocupacao), 32'd16);
`ifdef PILHA_CIRCULAR_EN
    chk("ovf_topo", bus.topo, 32'd17);
    for (int i = 0; i < 16; i++) begin
      chk("drain_topo", bus.topo, 32'(17 - i));
      step(0, 1, 32'd0);
    end
`else
    chk("ovf_topo", bus.topo, 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_topo", bus.topo, 32'(16 - i));
      step(0, 1, 32'd0);
    end
`endif
    bus.pop = 1'b0;
    chk("drain_vazia", 32'(bus.vazia), 32'd1);
    chk("drain_unf", 32'(bus.erro_underflow), 32'd0);

    step(0, 1, 32'd0);
    bus.pop = 1'b0;
    chk("unf_flag", 32'(bus.erro_underflow), 32'd1);
    chk("unf_ocup", 32'(bus.ocupacao), 32'd0);
    chk("unf_topo", bus.topo, 32'd0);
    repeat (5) @(negedge clk);
    chk("unf_sticky", 32'(bus.erro_underflow), 32'd1);
    chk("ovf_sticky", 32'(bus.erro_overflow), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("unf_cleared", 32'(bus.erro_underflow), 32'd0);
    chk("ovf_cleared", 32'(bus.erro_overflow), 32'd0);

    for (int i = 1; i <= 5; i++) step(1, 0, 32'(i * 3));
    bus.push = 1'b0;
    chk("pre_rst_ocup", 32'(bus.ocupacao), 32'd5);
    chk("pre_rst_topo", bus.topo, 32'd15);
    reset = 1'b1;
    step(1, 0, 32'h55);
    reset = 1'b0;
    bus.push = 1'b0;
    chk("rstpush_ocup", 32'(bus.ocupacao), 32'd0);
    chk("rstpush_vazia", 32'(bus.vazia), 32'd1);
    chk("rstpush_topo", bus.topo, 32'd0);
    chk("rstpush_ovf", 32'(bus.erro_overflow), 32'd0);
    chk("rstpush_unf", 32'(bus.erro_underflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pilha_hw.md
Name: pilha_hw

Overview:
- Hardware LIFO return/data stack driven by the multicycle control unit's push/pop strobes.
- Stores PC+1 on jal, register data on lstk, and supplies the top-of-stack for jst (to the PC mux) and sstk (to the memory data mux).
- Top-of-stack output is valid before the pop edge. The consumer reads the top word during the same cycle that pop is high.
- Sits between the stack-source mux (driven by SelMuxPilha) and the PC and memory-data muxes.

Parameters:
- LARGURA, 32, data word width in bits.
- PROFUNDIDADE, 16, number of entries; must be a power of 2 and ≥ 2.
- PONT_W, 4, pointer width, equal to log2(PROFUNDIDADE).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write dado_in on top; level sampled each posedge.
- pop  input  1  remove the top entry; level sampled each posedge.
- dado_in  input  LARGURA  word to push, from the stack-source mux.
- topo  output  LARGURA  current top entry; combinational read of mem[sp-1].
- vazia  output  1  stack holds 0 entries.
- cheia  output  1  stack holds PROFUNDIDADE entries.
- ocupacao  output  PONT_W+1  current entry count, 0..PROFUNDIDADE.
- erro_overflow  output  1  sticky flag; set by a push while full.
- erro_underflow  output  1  sticky flag; set by a pop while empty.

Behaviour:
- State: memory array mem[0..PROFUNDIDADE-1], count register sp (PONT_W+1 bits), two sticky error flags.
- Reset (synchronous, has priority over push/pop):
  - sp=0, erro_overflow=0, erro_underflow=0.
  - Memory contents are not cleared.
  - Outputs after reset: vazia=1, cheia=0, ocupacao=0, topo=0.
- topo:
  - Equals mem[sp-1] when sp>0, otherwise 0.
  - Purely combinational from registered state, so there is zero-cycle read latency.
- Push only (push=1, pop=0):
  - Not full: mem[sp] <= dado_in, sp <= sp+1. The new top is visible on topo the cycle after the edge.
  - Full: write is dropped, sp unchanged, erro_overflow <= 1.
- Pop only (push=0, pop=1):
  - Not empty: sp <= sp-1. The old topo value was available throughout the cycle before the edge.
  - Empty: sp unchanged, erro_underflow <= 1.
- Push and pop together:
  - Not empty: replace the top, mem[sp-1] <= dado_in, sp unchanged.
  - Empty: behaves as push only, and erro_underflow is not set.
- Neither asserted: hold all state.
- Strobe width: the control unit holds push/pop high for exactly one clk period (asserted on negedge, sampled on the next posedge). The block must not edge-detect; a strobe held for N cycles performs N operations.
- Flags:
  - vazia = (sp==0), cheia = (sp==PROFUNDIDADE), ocupacao = sp; all combinational from sp.
  - Error flags stay set until reset.
- Reset mid-operation: a reset coinciding with a push or pop wins. Stack is empty afterwards and the write is lost.
- No X on outputs after the first reset edge.

Optional Feature:
- Macro: PILHA_CIRCULAR_EN.
- Defined:
  - Push while full overwrites the oldest entry (ring buffer). Base pointer advances, sp stays PROFUNDIDADE, cheia stays 1.
  - erro_overflow is still set, to mark the data loss.
  - Pop and topo operate on the newest PROFUNDIDADE entries.
- Undefined: push while full is dropped, as described in Behaviour.
- Underflow behaviour is identical in both builds.

Test Plan:
- Reset, then push 0x00000010, 0x00000020, 0x00000030 on consecutive cycles → ocupacao=3, topo=0x00000030, vazia=0.
- From that state, pop one cycle → topo read during the pop cycle is 0x00000030; after the edge topo=0x00000020, ocupacao=2.
- Push and pop together with dado_in=0xDEADBEEF at ocupacao=2 → ocupacao=2, topo=0xDEADBEEF, no error flags set.
- Push 16 words 1..16, then push 17:
  - Build without PILHA_CIRCULAR_EN: cheia=1, topo=16, erro_overflow=1.
  - Build with PILHA_CIRCULAR_EN: topo=17; popping 16 times returns 17..2.
- Pop on an empty stack → erro_underflow=1, ocupacao=0, topo=0. The flag stays 1 through 5 idle cycles and clears only on reset.
- Assert reset in the same cycle as a push of 0x55 at ocupacao=5 → ocupacao=0, vazia=1, both error flags 0 on the next cycle.
